// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: lane steering, load extension and wait-state handling
// toward an ack-based word memory. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           byte_addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic                  mrd_i,
    input  logic                  mwr_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  busy_o,
    output logic                  rdy_o,
    output logic                  err_o,
    output logic [29:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [3:0]            mem_be_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    input  logic                  mem_ack_i
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  boff_q, boff_d;
    logic [2:0]  f3_q, f3_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic [31:0] rd_q, rd_d;
    logic        rdy_q, rdy_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        misalign_q, misalign_d;

    logic [3:0]  st_be;
    logic [31:0] st_wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        misaligned;

    always_comb begin
        st_be = 4'b1111;
        st_wd = wd_i;
        case (funct3_i)
            3'b000: begin
                st_be = 4'b0001 << byte_addr_i[1:0];
                st_wd = {4{wd_i[7:0]}};
            end
            3'b001: begin
                st_be = byte_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = mem_rd_i[{boff_q, 3'b000} +: 8];
        ld_half = mem_rd_i[{boff_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_rd_i;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (mwr_i) begin
            if (funct3_i == 3'b001) misaligned = byte_addr_i[0];
            if (funct3_i == 3'b010) misaligned = |byte_addr_i[1:0];
        end else begin
            if (funct3_i[1:0] == 2'b01) misaligned = byte_addr_i[0];
            if (funct3_i == 3'b010)     misaligned = |byte_addr_i[1:0];
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Request pulses and rdy are registered on the transition into REQ/DONE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        boff_d     = boff_q;
        f3_d       = f3_q;
        is_wr_d    = is_wr_q;
        wd_d       = wd_q;
        be_d       = be_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        rd_d       = rd_q;
        rdy_d      = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;
        case (state_q)
            S_IDLE: begin
                if (mrd_i | mwr_i) begin
                    addr_d     = byte_addr_i[31:2];
                    boff_d     = byte_addr_i[1:0];
                    f3_d       = funct3_i;
                    is_wr_d    = mwr_i;
                    wd_d       = st_wd;
                    be_d       = mwr_i ? st_be : 4'b0000;
                    cnt_d      = 8'd0;
                    err_d      = 1'b0;
                    misalign_d = 1'b0;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        rdy_d      = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        re_d    = ~mwr_i;
                        we_d    = mwr_i;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_ack_i) begin
                    if (!is_wr_q) rd_d = ld_val;
                    rdy_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    rd_d    = 32'h0;
                    err_d   = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: state_d = S_HOLD;
            S_HOLD: if (!(mrd_i | mwr_i)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            boff_q     <= '0;
            f3_q       <= '0;
            is_wr_q    <= 1'b0;
            wd_q       <= '0;
            be_q       <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            boff_q     <= boff_d;
            f3_q       <= f3_d;
            is_wr_q    <= is_wr_d;
            wd_q       <= wd_d;
            be_q       <= be_d;
            re_q       <= re_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign busy_o     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                        ((state_q == S_IDLE) && (mrd_i || mwr_i));
    assign rd_o       = rd_q;
    assign rdy_o      = rdy_q;
    assign err_o      = err_q;
    assign mem_addr_o = addr_q;
    assign mem_wd_o   = wd_q;
    assign mem_be_o   = be_q;
    assign mem_re_o   = re_q;
    assign mem_we_o   = we_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q ^ misaligned;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for lane steering and extension,
// hand sequences for timeout, late ack, reset mid-access and (optionally) misalign trap.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  funct3;
    logic [31:0] byteAddr;
    logic [31:0] wd;
    logic        mrd, mwr;
    logic [31:0] rd;
    logic        busy, rdy, err;
    logic [29:0] memAddr;
    logic [31:0] memWd;
    logic [3:0]  memBe;
    logic        memRe, memWe;
    logic [31:0] memRd;
    logic        memAck;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;
    int reCnt = 0;
    int weCnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
        .clk_i(clk), .reset_i(reset), .funct3_i(funct3), .byte_addr_i(byteAddr),
        .wd_i(wd), .mrd_i(mrd), .mwr_i(mwr), .rd_o(rd), .busy_o(busy), .rdy_o(rdy),
        .err_o(err), .mem_addr_o(memAddr), .mem_wd_o(memWd), .mem_be_o(memBe),
        .mem_re_o(memRe), .mem_we_o(memWe), .mem_rd_i(memRd), .mem_ack_i(memAck)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_o(misalign)
`endif
    );

    always @(negedge clk) begin
        if (memRe) reCnt++;
        if (memWe) weCnt++;
    end

    typedef struct {
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] expRd;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        logic [29:0] expAddr;
    } vec_t;

    vec_t vecs[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // One full access; ack is given in the cycle right after the request pulse.
    task automatic applyStimulus(input vec_t v, output logic [31:0] rdV, output logic [3:0] beV,
                                 output logic [31:0] wdV, output logic [29:0] addrV,
                                 output int busyN, output bit gotRdy);
        bit armed;
        armed  = 0;
        busyN  = 0;
        gotRdy = 0;
        rdV    = '0;
        beV    = '0;
        wdV    = '0;
        addrV  = '0;
        funct3   = v.f3;
        byteAddr = v.addr;
        wd       = v.wdata;
        mrd      = !v.wr;
        mwr      = v.wr;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busyN++;
            if (rdy) begin
                gotRdy = 1;
                rdV    = rd;
                break;
            end
            if (memRe || memWe) begin
                beV   = memBe;
                wdV   = memWd;
                addrV = memAddr;
                armed = 1;
            end else if (armed) begin
                memAck = 1'b1;
                memRd  = v.rdata;
                armed  = 0;
            end
            tick;
            memAck = 1'b0;
        end
        mrd = 1'b0;
        mwr = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        logic [31:0] rdV;
        logic [3:0]  beV;
        logic [31:0] wdV;
        logic [29:0] addrV;
        int          busyN;
        bit          gotRdy;
        int          reBefore, weBefore, doneAt, rdySeen;
        vec_t        v;

        reset = 1'b1; funct3 = 3'b000; byteAddr = '0; wd = '0;
        mrd = 1'b0; mwr = 1'b0; memRd = '0; memAck = 1'b0;
        tick; tick; tick;
        reset = 1'b0;
        tick;
        checkOutput("reset_rd", rd, 32'h0);
        checkOutput("reset_rdy", {31'h0, rdy}, 32'h0);
        checkOutput("reset_err", {31'h0, err}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_mem", {memAddr, memBe, memRe, memWe}, 36'h0);
        checkOutput("reset_memwd", memWd, 32'h0);

        //           wr f3      addr        wdata         rdata         expRd         be       expWd         wordaddr
        vecs.push_back('{0, 3'b010, 32'h040, 32'h0,        32'h87654321, 32'h87654321, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{0, 3'b000, 32'h042, 32'h0,        32'h80FF7F01, 32'hFFFFFFFF, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{0, 3'b100, 32'h043, 32'h0,        32'h80FF7F01, 32'h00000080, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{0, 3'b001, 32'h040, 32'h0,        32'h80FF7F01, 32'h00007F01, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{0, 3'b101, 32'h042, 32'h0,        32'h80FF7F01, 32'h000080FF, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{0, 3'b001, 32'h042, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{0, 3'b000, 32'h040, 32'h0,        32'h80FF7F01, 32'h00000001, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{1, 3'b000, 32'h103, 32'h123456AB, 32'hDEADBEEF, 32'h00000001, 4'b1000, 32'hABABABAB, 30'h040});
        vecs.push_back('{1, 3'b001, 32'h102, 32'h123456AB, 32'hDEADBEEF, 32'h00000001, 4'b1100, 32'h56AB56AB, 30'h040});
        vecs.push_back('{1, 3'b010, 32'h100, 32'h123456AB, 32'hDEADBEEF, 32'h00000001, 4'b1111, 32'h123456AB, 30'h040});
        vecs.push_back('{1, 3'b000, 32'h101, 32'h123456AB, 32'hDEADBEEF, 32'h00000001, 4'b0010, 32'hABABABAB, 30'h040});
        vecs.push_back('{1, 3'b001, 32'h100, 32'h123456AB, 32'hDEADBEEF, 32'h00000001, 4'b0011, 32'h56AB56AB, 30'h040});
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back('{0, 3'b001, 32'h041, 32'h0,        32'h80FF7F01, 32'h00007F01, 4'b0000, 32'h0,        30'h010});
        vecs.push_back('{1, 3'b010, 32'h102, 32'hCAFEF00D, 32'h0,        32'h00007F01, 4'b1111, 32'hCAFEF00D, 30'h040});
        vecs.push_back('{0, 3'b010, 32'h043, 32'h0,        32'h80FF7F01, 32'h80FF7F01, 4'b0000, 32'h0,        30'h010});
`endif

        foreach (vecs[k]) begin
            v = vecs[k];
            reBefore = reCnt;
            weBefore = weCnt;
            applyStimulus(v, rdV, beV, wdV, addrV, busyN, gotRdy);
            checkOutput($sformatf("v%0d_rdy", k), {31'h0, gotRdy}, 32'h1);
            checkOutput($sformatf("v%0d_rd", k), rdV, v.expRd);
            checkOutput($sformatf("v%0d_be", k), {28'h0, beV}, {28'h0, v.expBe});
            checkOutput($sformatf("v%0d_addr", k), {2'b00, addrV}, {2'b00, v.expAddr});
            if (v.wr) checkOutput($sformatf("v%0d_wd", k), wdV, v.expWd);
            checkOutput($sformatf("v%0d_busy", k), busyN, 3);
            checkOutput($sformatf("v%0d_re", k), reCnt - reBefore, v.wr ? 0 : 1);
            checkOutput($sformatf("v%0d_we", k), weCnt - weBefore, v.wr ? 1 : 0);
            checkOutput($sformatf("v%0d_err", k), {31'h0, err}, 32'h0);
        end

        // Timeout: no ack at all, strobe held long after completion.
        reBefore = reCnt;
        funct3 = 3'b010; byteAddr = 32'h080; mrd = 1'b1;
        #1;
        doneAt = -1;
        for (int i = 0; i < 40; i++) begin
            if (rdy) begin
                doneAt = i;
                break;
            end
            tick;
        end
        checkOutput("to_latency", doneAt, 17);
        checkOutput("to_err", {31'h0, err}, 32'h1);
        checkOutput("to_rd", rd, 32'h0);
        rdySeen = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (rdy) rdySeen++;
        end
        mrd = 1'b0;
        tick; tick;
        repeat (20) tick;
        memAck = 1'b1; memRd = 32'h55AA55AA;
        tick;
        if (rdy) rdySeen++;
        memAck = 1'b0;
        tick;
        if (rdy) rdySeen++;
        checkOutput("to_no_rdy_again", rdySeen, 0);
        checkOutput("to_single_re", reCnt - reBefore, 1);
        checkOutput("late_ack_rd", rd, 32'h0);
        checkOutput("late_ack_err", {31'h0, err}, 32'h1);

        v = '{0, 3'b010, 32'h044, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000, 32'h0, 30'h011};
        applyStimulus(v, rdV, beV, wdV, addrV, busyN, gotRdy);
        checkOutput("after_to_rd", rdV, 32'hCAFEF00D);
        checkOutput("after_to_err", {31'h0, err}, 32'h0);

        // Reset while waiting for ack.
        funct3 = 3'b010; byteAddr = 32'h0C0; mrd = 1'b1;
        #1;
        tick;
        checkOutput("rst_req_re", {31'h0, memRe}, 32'h1);
        tick;
        reset = 1'b1; mrd = 1'b0;
        tick;
        reset = 1'b0;
        checkOutput("rst_rd", rd, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_mem", {memAddr, memBe, memRe, memWe}, 36'h0);
        reBefore = reCnt;
        rdySeen  = 0;
        for (int i = 0; i < 6; i++) begin
            memAck = (i == 1);
            tick;
            if (rdy) rdySeen++;
        end
        memAck = 1'b0;
        checkOutput("rst_no_re", reCnt - reBefore, 0);
        checkOutput("rst_no_rdy", rdySeen, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word load is trapped without touching memory.
        reBefore = reCnt;
        funct3 = 3'b010; byteAddr = 32'h042; mrd = 1'b1;
        #1;
        checkOutput("mis_busy_accept", {31'h0, busy}, 32'h1);
        tick;
        checkOutput("mis_rdy", {31'h0, rdy}, 32'h1);
        checkOutput("mis_flag", {31'h0, misalign}, 32'h1);
        checkOutput("mis_busy_done", {31'h0, busy}, 32'h0);
        checkOutput("mis_rd", rd, 32'h0);
        mrd = 1'b0;
        tick; tick;
        checkOutput("mis_no_re", reCnt - reBefore, 0);
        checkOutput("mis_flag_held", {31'h0, misalign}, 32'h1);
        v = '{0, 3'b010, 32'h040, 32'h0, 32'h87654321, 32'h87654321, 4'b0000, 32'h0, 30'h010};
        applyStimulus(v, rdV, beV, wdV, addrV, busyN, gotRdy);
        checkOutput("mis_clear", {31'h0, misalign}, 32'h0);
        checkOutput("mis_clear_rd", rdV, 32'h87654321);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
